// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures pwm_in high time in clk3 cycles, validates it against
// [MIN_WIDTH, MAX_WIDTH] and tracks frame loss. Optional debounce: SERVO_DECODE_GLITCH_FILTER_EN.
module servo_pwm_decoder #(
  parameter int MIN_WIDTH     = 23000,
  parameter int MAX_WIDTH     = 127000,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic        clk3,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [16:0] width,
  output logic        width_valid,
  output logic        pulse_err,
  output logic        signal_lost,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } state_t;

  localparam logic [16:0] MIN_W    = 17'(MIN_WIDTH);
  localparam logic [16:0] MAX_W    = 17'(MAX_WIDTH);
  localparam logic [16:0] HCNT_SAT = 17'(MAX_WIDTH + 1);
  localparam logic [19:0] FT       = 20'(FRAME_TIMEOUT);
  localparam logic [19:0] FT_M1    = 20'(FRAME_TIMEOUT - 1);

  // Synchronizer runs through reset so a line already high at release reads as high.
  logic sync_a;
  logic s;
  logic cur;
  logic prev;

  always_ff @(posedge clk3) begin
    sync_a <= pwm_in;
    s      <= sync_a;
  end

`ifdef SERVO_DECODE_GLITCH_FILTER_EN
  logic [2:0] s_hist;
  logic       filt_q;

  always_ff @(posedge clk3) begin
    s_hist <= {s_hist[1:0], s};
    filt_q <= cur;
  end

  // Filtered level follows s only once four consecutive samples agree.
  always_comb begin
    cur = filt_q;
    if ((s == s_hist[0]) && (s == s_hist[1]) && (s == s_hist[2])) cur = s;
  end

  assign prev = filt_q;
`else
  logic s_prev;

  always_ff @(posedge clk3) begin
    s_prev <= s;
  end

  assign cur  = s;
  assign prev = s_prev;
`endif

  logic rise;
  logic fall;

  assign rise = cur & ~prev;
  assign fall = ~cur & prev;

  state_t      state, state_n;
  logic [16:0] hcnt, hcnt_n;
  logic [19:0] fcnt, fcnt_n;
  logic [16:0] width_n;
  logic        valid_n;
  logic        err_n;
  logic        lost_n;

  always_ff @(posedge clk3) begin
    if (reset) begin
      state       <= WAIT_LOW;
      hcnt        <= '0;
      fcnt        <= '0;
      width       <= '0;
      width_valid <= 1'b0;
      pulse_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_n;
      hcnt        <= hcnt_n;
      fcnt        <= fcnt_n;
      width       <= width_n;
      width_valid <= valid_n;
      pulse_err   <= err_n;
      signal_lost <= lost_n;
    end
  end

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    fcnt_n  = fcnt;
    width_n = width;
    valid_n = 1'b0;
    err_n   = 1'b0;
    lost_n  = signal_lost;

    // Loss flags the cycle fcnt reaches FT; an acceptance below overrides it.
    if (rise) begin
      fcnt_n = '0;
    end else begin
      if (fcnt < FT) fcnt_n = fcnt + 20'd1;
      if (fcnt >= FT_M1) lost_n = 1'b1;
    end

    case (state)
      WAIT_LOW: begin
        if (!cur) state_n = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          hcnt_n  = 17'd1;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if ((hcnt >= MIN_W) && (hcnt <= MAX_W)) begin
            width_n = hcnt;
            valid_n = 1'b1;
            lost_n  = 1'b0;
          end else begin
            err_n = 1'b1;
          end
          state_n = WAIT_RISE;
        end else begin
          if (hcnt < HCNT_SAT) hcnt_n = hcnt + 17'd1;
          // Over-long pulse is rejected once; its eventual fall is ignored.
          if (hcnt_n == HCNT_SAT) begin
            err_n   = 1'b1;
            state_n = WAIT_LOW;
          end
        end
      end
      default: state_n = WAIT_LOW;
    endcase
  end

  assign dbg_state = state;

endmodule
